// File: rtl/scu_param.sv
// scu_param -- parametrised single-bus control-unit processor.
//
// A multi-cycle control FSM (T0..T3) moves data between WIDTH-bit general
// registers R0..R(NREGS-1), the ALU operand register A, the ALU result
// register G and the external input Din. Everything moves over one shared
// bus, which is driven through a one-hot source select.
//
// Instruction word (Din[IW-1:0], IW = 4+2*RW): {op[3:0], rx[RW-1:0], ry[RW-1:0]}
//   0 mv    Rx <- Ry                       (1 step)
//   1 mvi   Rx <- Din (immediate in T1)    (1 step)
//   2 add / 3 sub / 4 and / 5 or / 6 xor   (3 steps: A<-Rx, G<-A op Ry, Rx<-G)
//   7 mvnz  Rx <- Ry only when G != 0      (1 step)
//   others  NOP, Done in T1
//
// Optional feature macro: SCU_LOGIC_OPS_EN
//   defined   : opcodes 4/5/6 run as and/or/xor.
//   undefined : opcodes 4/5/6 decode as illegal NOPs, and the ALU has no
//               logic-op hardware.
//
// Ports:
//   clk   in  1      rising-edge clock
//   Reset in  1      synchronous, active-high; overrides everything else
//   Run   in  1      start request, sampled only in T0
//   Din   in  WIDTH  instruction word in T0, immediate in mvi T1
//   Done  out 1      high in the final cycle of each instruction
//   bus   out WIDTH  shared datapath bus (combinational)
module scu_param #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Din,
  output logic             Done,
  output logic [WIDTH-1:0] bus
);

  localparam int IW = 4 + 2 * RW;

  localparam logic [1:0] ST_T0 = 2'd0;
  localparam logic [1:0] ST_T1 = 2'd1;
  localparam logic [1:0] ST_T2 = 2'd2;
  localparam logic [1:0] ST_T3 = 2'd3;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_ir;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_regs [NREGS];

  logic [3:0]       w_op;
  logic [RW-1:0]    w_rx;
  logic [RW-1:0]    w_ry;
  logic             w_is_alu;

  // One-hot bus select, split into its register, G and Din parts.
  logic [NREGS-1:0] w_sel_r;
  logic             w_sel_g;
  logic             w_sel_din;

  logic             w_rin;
  logic             w_ain;
  logic             w_gin;
  logic             w_irin;
  logic             w_done;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] w_bus;
  logic [WIDTH-1:0] w_alu;
  logic             w_unused_din;

  assign w_op = r_ir[IW-1 -: 4];
  assign w_rx = r_ir[2*RW-1 -: RW];
  assign w_ry = r_ir[RW-1:0];

  // Din bits above the instruction field only matter as immediate data.
  assign w_unused_din = ^Din;

`ifdef SCU_LOGIC_OPS_EN
  assign w_is_alu = (w_op >= 4'd2) && (w_op <= 4'd6);
`else
  assign w_is_alu = (w_op == 4'd2) || (w_op == 4'd3);
`endif

  // Control decode: select lines, write enables, Done and next state.
  always_comb begin
    w_sel_r   = '0;
    w_sel_g   = 1'b0;
    w_sel_din = 1'b0;
    w_rin     = 1'b0;
    w_ain     = 1'b0;
    w_gin     = 1'b0;
    w_irin    = 1'b0;
    w_done    = 1'b0;
    w_next    = r_state;
    case (r_state)
      ST_T0: begin
        if (Run) begin
          w_irin = 1'b1;
          w_next = ST_T1;
        end
      end
      ST_T1: begin
        if (w_is_alu) begin
          w_sel_r[w_rx] = 1'b1;
          w_ain         = 1'b1;
          w_next        = ST_T2;
        end else begin
          w_done = 1'b1;
          w_next = ST_T0;
          case (w_op)
            4'd0: begin
              w_sel_r[w_ry] = 1'b1;
              w_rin         = 1'b1;
            end
            4'd1: begin
              w_sel_din = 1'b1;
              w_rin     = 1'b1;
            end
            4'd7: begin
              w_sel_r[w_ry] = 1'b1;
              w_rin         = (r_g != '0);
            end
            default: ;
          endcase
        end
      end
      ST_T2: begin
        w_sel_r[w_ry] = 1'b1;
        w_gin         = 1'b1;
        w_next        = ST_T3;
      end
      default: begin
        w_sel_g = 1'b1;
        w_rin   = 1'b1;
        w_done  = 1'b1;
        w_next  = ST_T0;
      end
    endcase
  end

  // AND-OR bus mux; with no select active the bus reads zero.
  always_comb begin
    w_bus = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (w_sel_r[RW'(i)]) w_bus = w_bus | r_regs[RW'(i)];
    end
    if (w_sel_g)   w_bus = w_bus | r_g;
    if (w_sel_din) w_bus = w_bus | Din;
  end

  // A holds Rx captured in T1, so rx==ry operations see the old Rx twice.
  always_comb begin
    w_alu = '0;
    case (w_op)
      4'd2: w_alu = r_a + w_bus;
      4'd3: w_alu = r_a - w_bus;
`ifdef SCU_LOGIC_OPS_EN
      4'd4: w_alu = r_a & w_bus;
      4'd5: w_alu = r_a | w_bus;
      4'd6: w_alu = r_a ^ w_bus;
`endif
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= ST_T0;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[RW'(i)] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_irin) r_ir <= Din[IW-1:0];
      if (w_ain)  r_a  <= w_bus;
      if (w_gin)  r_g  <= w_alu;
      if (w_rin)  r_regs[w_rx] <= w_bus;
    end
  end

  assign bus  = w_bus;
  assign Done = w_done;

endmodule

// File: tb/tb_scu_param.sv
module tb_scu_param;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;

`ifdef SCU_LOGIC_OPS_EN
  localparam bit LOGIC_EN = 1'b1;
`else
  localparam bit LOGIC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic        Run;
  logic [15:0] Din;
  logic        Done;
  logic [15:0] bus;

  scu_param #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk  (clk),
    .Reset(Reset),
    .Run  (Run),
    .Din  (Din),
    .Done (Done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: expected {Done, bus} for one clock cycle.
  typedef struct {
    logic [16:0] v;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_r [8];
  logic [15:0] m_g;

  // Exactly one entry is pushed per cycle (just after the rising edge) and
  // popped here on the falling edge of that same cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({Done, bus} !== e.v) begin
        failures++;
        $display("FAIL %s: got Done=%0b bus=%h, expected Done=%0b bus=%h",
                 e.name, Done, bus, e.v[16], e.v[15:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rx,
                                      input logic [2:0] ry);
    return {6'd0, op, rx, ry};
  endfunction

  task automatic push(input logic d, input logic [15:0] b, input string name);
    exp_t e;
    e.v    = {d, b};
    e.name = name;
    q.push_back(e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_g = '0;
  endtask

  // Issue one instruction from T0; expected per-cycle bus/Done come from the
  // reference model. hold keeps Run high throughout, pulse raises Run only
  // in step 1/2/3 of the instruction.
  task automatic issue(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [15:0] imm, input bit hold, input int pulse,
                       input string tag);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    Din = enc(op, rx, ry);
    Run = 1'b1;
    push(1'b0, 16'h0, {tag, " T0"});
    @(posedge clk); #1;
    Run = hold || (pulse == 1);
    Din = imm;
    if (op == 4'd0 || op == 4'd7) begin
      push(1'b1, m_r[ry], {tag, " T1"});
      if (op == 4'd0 || m_g != 16'h0) m_r[rx] = m_r[ry];
    end else if (op == 4'd1) begin
      push(1'b1, imm, {tag, " T1"});
      m_r[rx] = imm;
    end else if (op == 4'd2 || op == 4'd3 || (LOGIC_EN && op >= 4'd4 && op <= 4'd6)) begin
      a = m_r[rx];
      push(1'b0, a, {tag, " T1"});
      @(posedge clk); #1;
      Run = hold || (pulse == 2);
      b = m_r[ry];
      push(1'b0, b, {tag, " T2"});
      case (op)
        4'd2:    res = a + b;
        4'd3:    res = a - b;
        4'd4:    res = a & b;
        4'd5:    res = a | b;
        default: res = a ^ b;
      endcase
      m_g = res;
      @(posedge clk); #1;
      Run = hold || (pulse == 3);
      push(1'b1, res, {tag, " T3"});
      m_r[rx] = res;
    end else begin
      push(1'b1, 16'h0, {tag, " T1 nop"});
    end
    @(posedge clk); #1;
    Run = hold;
  endtask

  // Observe a register by issuing mv Rr,Rr: T1 shows Rr on the bus. The
  // expected value is supplied by the caller as a fixed constant.
  task automatic read_reg(input logic [2:0] r, input logic [15:0] expv, input string tag);
    Din = enc(4'd0, r, r);
    Run = 1'b1;
    push(1'b0, 16'h0, {tag, " T0"});
    @(posedge clk); #1;
    Run = 1'b0;
    push(1'b1, expv, tag);
    checks++;
    if ({Done, bus} !== {1'b1, expv}) begin
      failures++;
      $display("FAIL %s direct: got Done=%0b bus=%h, expected Done=1 bus=%h",
               tag, Done, bus, expv);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input string tag);
    Run = 1'b0;
    for (int i = 0; i < n; i++) begin
      push(1'b0, 16'h0, tag);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Run   = 1'b1;
    Din   = enc(4'd1, 3'd2, 3'd0);
    @(posedge clk); #1;
    push(1'b0, 16'h0, "reset cycle1");
    @(posedge clk); #1;
    Reset = 1'b0;
    Run   = 1'b0;
    push(1'b0, 16'h0, "reset cycle2");
    clear_model();
    @(posedge clk); #1;
    issue(4'd0, 3'd2, 3'd0, 16'h0, 1'b0, 0, "reset mv R2,R0");
    read_reg(3'd2, 16'h0000, "reset R2");
  endtask

  task automatic test_alu_add();
    issue(4'd1, 3'd0, 3'd0, 16'd5, 1'b0, 0, "mvi R0,5");
    issue(4'd1, 3'd1, 3'd0, 16'd3, 1'b0, 0, "mvi R1,3");
    issue(4'd2, 3'd0, 3'd1, 16'h0, 1'b0, 0, "add R0,R1");
    read_reg(3'd0, 16'd8, "add R0");
  endtask

  task automatic test_sub_mvnz();
    issue(4'd3, 3'd1, 3'd0, 16'h0, 1'b0, 0, "sub R1,R0");
    read_reg(3'd1, 16'hFFFB, "sub R1");
    issue(4'd7, 3'd2, 3'd1, 16'h0, 1'b0, 0, "mvnz R2,R1 G!=0");
    read_reg(3'd2, 16'hFFFB, "mvnz R2");
    issue(4'd1, 3'd4, 3'd0, 16'h1234, 1'b0, 0, "mvi R4");
    issue(4'd3, 3'd3, 3'd3, 16'h0, 1'b0, 0, "sub R3,R3");
    issue(4'd7, 3'd4, 3'd1, 16'h0, 1'b0, 0, "mvnz R4,R1 G==0");
    read_reg(3'd4, 16'h1234, "mvnz R4 unchanged");
  endtask

  task automatic test_rx_eq_ry();
    issue(4'd1, 3'd5, 3'd0, 16'h8001, 1'b0, 0, "mvi R5");
    issue(4'd2, 3'd5, 3'd5, 16'h0, 1'b0, 0, "add R5,R5");
    read_reg(3'd5, 16'h0002, "add R5,R5 wrap");
  endtask

  task automatic test_run_ignored();
    issue(4'd2, 3'd0, 3'd1, enc(4'd1, 3'd6, 3'd0), 1'b0, 2, "add run@T2");
    idle(2, "idle after run@T2");
    read_reg(3'd0, 16'h0003, "R0 after run@T2");
    issue(4'd2, 3'd0, 3'd1, enc(4'd1, 3'd6, 3'd0), 1'b0, 3, "add run@T3");
    idle(2, "idle after run@T3");
    read_reg(3'd0, 16'hFFFE, "R0 after run@T3");
  endtask

  task automatic test_reset_mid();
    issue(4'd1, 3'd0, 3'd0, 16'd1, 1'b0, 0, "mvi R0,1");
    issue(4'd1, 3'd1, 3'd0, 16'd2, 1'b0, 0, "mvi R1,2");
    Din = enc(4'd2, 3'd0, 3'd1);
    Run = 1'b1;
    push(1'b0, 16'h0, "rstmid T0");
    @(posedge clk); #1;
    Run = 1'b0;
    push(1'b0, 16'd1, "rstmid T1");
    @(posedge clk); #1;
    Reset = 1'b1;
    push(1'b0, 16'd2, "rstmid T2");
    @(posedge clk); #1;
    Reset = 1'b0;
    clear_model();
    push(1'b0, 16'h0, "rstmid after reset");
    @(posedge clk); #1;
    idle(1, "rstmid idle");
    read_reg(3'd0, 16'h0000, "rstmid R0");
    read_reg(3'd1, 16'h0000, "rstmid R1");
  endtask

  task automatic test_back_to_back();
    issue(4'd1, 3'd6, 3'd0, 16'h00AA, 1'b1, 0, "b2b mvi R6");
    issue(4'd1, 3'd7, 3'd0, 16'h0055, 1'b1, 0, "b2b mvi R7");
    issue(4'd2, 3'd6, 3'd7, 16'h0, 1'b1, 0, "b2b add R6,R7");
    issue(4'd0, 3'd3, 3'd6, 16'h0, 1'b0, 0, "b2b mv R3,R6");
    read_reg(3'd3, 16'h00FF, "b2b R3");
  endtask

  task automatic test_logic_ops();
    issue(4'd1, 3'd0, 3'd0, 16'h00F0, 1'b0, 0, "mvi R0,F0");
    issue(4'd1, 3'd1, 3'd0, 16'h0F0F, 1'b0, 0, "mvi R1,0F0F");
    issue(4'd5, 3'd0, 3'd1, 16'h0, 1'b0, 0, "op5 R0,R1");
    read_reg(3'd0, LOGIC_EN ? 16'h0FFF : 16'h00F0, "op5 R0");
    issue(4'd6, 3'd1, 3'd0, 16'h0, 1'b0, 0, "op6 R1,R0");
    read_reg(3'd1, LOGIC_EN ? 16'h00F0 : 16'h0F0F, "op6 R1");
    issue(4'd12, 3'd0, 3'd1, 16'h0, 1'b0, 0, "op12 nop");
    read_reg(3'd0, LOGIC_EN ? 16'h0FFF : 16'h00F0, "op12 R0");
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    Din   = '0;
    clear_model();
    test_reset();
    test_alu_add();
    test_sub_mvnz();
    test_rx_eq_ry();
    test_run_ignored();
    test_reset_mid();
    test_back_to_back();
    test_logic_ops();
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d expected cycles never compared", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
